ex_hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RV32I core. It sits beside the ID/EX buffer and produces three kinds of control.
- Registered forward-mux selects (fa/fb) for the Execute stage.
- Load-use stall sequencing.
- Multi-cycle flush sequencing when Execute raises a redirect.
A 3-state FSM (RUN, STALL, FLUSH) owns the stall/bubble/flush strobes seen by Fetch, Decode and the ID/EX buffer.

---
 rtl/ex_hazard_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX forward selects, load-use stall and redirect flush sequencing.
// Define HAZARD_PERF_CNT_EN to add the stall/flush cycle counters.
module ex_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       id_valid,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_reg_write,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd_addr,
  input  logic       mem_reg_write,
  input  logic       ex_flush_ip,
  output logic [1:0] fa_mux_op,
  output logic [1:0] fb_mux_op,
  output logic       stall_if_op,
  output logic       stall_id_op,
  output logic       bubble_ex_op,
  output logic       flush_if_id_op,
  output logic       flush_id_ex_op
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_count_op,
  output logic [31:0] flush_count_op
`endif
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx, fa_sel, fb_sel;
  logic rs1_ok, rs2_ok, load_use, stall, flush;
  assign rs1_ok = id_valid && id_rs1_used && id_rs1_addr != 5'd0;
  assign rs2_ok = id_valid && id_rs2_used && id_rs2_addr != 5'd0;
  assign fa_sel = !rs1_ok ? 2'd0 :
                  (ex_reg_write && !ex_is_load && id_rs1_addr == ex_rd_addr) ? 2'd1 :
                  (mem_reg_write && id_rs1_addr == mem_rd_addr) ? 2'd2 : 2'd0;
  assign fb_sel = !rs2_ok ? 2'd0 :
                  (ex_reg_write && !ex_is_load && id_rs2_addr == ex_rd_addr) ? 2'd1 :
                  (mem_reg_write && id_rs2_addr == mem_rd_addr) ? 2'd2 : 2'd0;
  assign load_use = ex_is_load && ex_reg_write && ex_rd_addr != 5'd0 &&
                    ((rs1_ok && id_rs1_addr == ex_rd_addr) || (rs2_ok && id_rs2_addr == ex_rd_addr));
  // FLUSH and STALL are only ever entered with a nonzero count, so a zero
  // remaining count always leaves through RUN on the same edge.
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    stall = 1'b0;
    flush = 1'b0;
    if (ex_flush_ip) begin
      flush = 1'b1;
      state_nx = FLUSH_INIT != 2'd0 ? FLUSH : RUN;
      cnt_nx = FLUSH_INIT;
    end else if (state == FLUSH) begin
      flush = 1'b1;
      cnt_nx = cnt - 2'd1;
      state_nx = cnt == 2'd1 ? RUN : FLUSH;
    end else if (state == STALL) begin
      stall = 1'b1;
      cnt_nx = cnt - 2'd1;
      state_nx = cnt == 2'd1 ? RUN : STALL;
    end else if (load_use) begin
      stall = 1'b1;
      state_nx = STALL_INIT != 2'd0 ? STALL : RUN;
      cnt_nx = STALL_INIT;
    end
  end
  assign stall_if_op = stall && reset;
  assign stall_id_op = stall && reset;
  assign bubble_ex_op = stall && reset;
  assign flush_if_id_op = flush && reset;
  assign flush_id_ex_op = flush && reset;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt <= 2'd0;
      fa_mux_op <= 2'd0;
      fb_mux_op <= 2'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      fa_mux_op <= (stall || flush) ? 2'd0 : fa_sel;
      fb_mux_op <= (stall || flush) ? 2'd0 : fb_sel;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count_op <= 32'd0;
      flush_count_op <= 32'd0;
    end else begin
      stall_count_op <= stall_count_op + {31'd0, stall};
      flush_count_op <= flush_count_op + {31'd0, flush};
    end
  end
`endif
endmodule
